// File: rtl/immu_pkg.sv
// Shared types and helpers for the Sv39 instruction MMU.
//  - immu_state_e : walker/front-end FSM states
//  - SATP_MODE_*  : satp.MODE encodings that matter here
//  - PTE_*        : bit positions of the Sv39 PTE flag field
//  - tlb_entry_t  : one fully-associative iTLB entry
//  - vpn_match    : VPN compare honouring superpage level
//  - leaf_paddr   : physical address build for 4K/2M/1G leaves
package immu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WALK_AR,
        ST_WALK_R,
        ST_RESP,
        ST_FLUSH
    } immu_state_e;

    localparam logic [3:0] SATP_MODE_BARE = 4'd0;
    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    typedef struct packed {
        logic        valid;
        logic [26:0] vpn;
        logic [15:0] asid;
        logic        g;
        logic [1:0]  level;
        logic [43:0] ppn;
        logic        x;
        logic        u;
    } tlb_entry_t;

    // Level 2 = 1G page (only VPN[2] compared), level 1 = 2M, level 0 = 4K.
    function automatic logic vpn_match(input logic [26:0] a, input logic [26:0] b,
                                       input logic [1:0] level);
        logic m;
        m = (a[26:18] == b[26:18]);
        if (level < 2'd2) m = m && (a[17:9] == b[17:9]);
        if (level == 2'd0) m = m && (a[8:0] == b[8:0]);
        return m;
    endfunction

    function automatic logic [63:0] leaf_paddr(input logic [43:0] ppn, input logic [63:0] va,
                                               input logic [1:0] level);
        logic [63:0] pa;
        case (level)
            2'd2:    pa = {8'b0, ppn[43:18], va[29:0]};
            2'd1:    pa = {8'b0, ppn[43:9],  va[20:0]};
            default: pa = {8'b0, ppn,        va[11:0]};
        endcase
        return pa;
    endfunction

endpackage

// File: rtl/immu_tlb.sv
// Fully-associative, ASID-tagged iTLB.
//  clk_i/rst_ni        clock, async active-low reset (clears all valid bits, fill pointer)
//  lookup_*_i          combinational lookup key; hit_*_o report the matching entry
//  fill_*_i            write one entry at the round-robin pointer, pointer advances
//  flush_*_i           sfence.vma invalidate, filtered by VA and/or ASID
module immu_tlb
    import immu_pkg::*;
#(
    parameter int TLB_ENTRIES = 8,
    parameter int ASID_W      = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [26:0] lookup_vpn_i,
    input  logic [15:0] lookup_asid_i,
    output logic        hit_o,
    output logic [1:0]  hit_level_o,
    output logic [43:0] hit_ppn_o,
    output logic        hit_x_o,
    output logic        hit_u_o,
    input  logic        fill_i,
    input  logic [26:0] fill_vpn_i,
    input  logic [15:0] fill_asid_i,
    input  logic        fill_g_i,
    input  logic [1:0]  fill_level_i,
    input  logic [43:0] fill_ppn_i,
    input  logic        fill_x_i,
    input  logic        fill_u_i,
    input  logic        flush_i,
    input  logic [26:0] flush_vpn_i,
    input  logic [15:0] flush_asid_i,
    input  logic        flush_all_va_i,
    input  logic        flush_all_asid_i
);

    localparam int          PTR_W     = $clog2(TLB_ENTRIES);
    localparam logic [15:0] ASID_MASK = 16'((32'd1 << ASID_W) - 32'd1);

    tlb_entry_t [TLB_ENTRIES-1:0] tlb_q, tlb_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [TLB_ENTRIES-1:0]       hit_vec;
    tlb_entry_t                   fill_e;

    function automatic logic asid_eq(input logic [15:0] a, input logic [15:0] b);
        return ((a ^ b) & ASID_MASK) == 16'd0;
    endfunction

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < TLB_ENTRIES; i++)
            hit_vec[i] = tlb_q[i].valid && vpn_match(tlb_q[i].vpn, lookup_vpn_i, tlb_q[i].level)
                         && (tlb_q[i].g || asid_eq(tlb_q[i].asid, lookup_asid_i));
    end

    // Lowest index wins; fills never duplicate a live mapping, so this is just a mux.
    always_comb begin
        hit_o       = 1'b0;
        hit_level_o = '0;
        hit_ppn_o   = '0;
        hit_x_o     = 1'b0;
        hit_u_o     = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_o       = 1'b1;
                hit_level_o = tlb_q[i].level;
                hit_ppn_o   = tlb_q[i].ppn;
                hit_x_o     = tlb_q[i].x;
                hit_u_o     = tlb_q[i].u;
            end
        end
    end

    always_comb begin
        fill_e       = '0;
        fill_e.valid = 1'b1;
        fill_e.vpn   = fill_vpn_i;
        fill_e.asid  = fill_asid_i & ASID_MASK;
        fill_e.g     = fill_g_i;
        fill_e.level = fill_level_i;
        fill_e.ppn   = fill_ppn_i;
        fill_e.x     = fill_x_i;
        fill_e.u     = fill_u_i;
    end

    // Global entries survive an ASID-filtered flush; only rs2==x0 removes them.
    always_comb begin
        tlb_d = tlb_q;
        ptr_d = ptr_q;
        if (flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if ((flush_all_va_i || vpn_match(tlb_q[i].vpn, flush_vpn_i, tlb_q[i].level)) &&
                    (flush_all_asid_i || (!tlb_q[i].g && asid_eq(tlb_q[i].asid, flush_asid_i))))
                    tlb_d[i].valid = 1'b0;
            end
        end
        if (fill_i) begin
            tlb_d[ptr_q] = fill_e;
            ptr_d        = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tlb_q <= '0;
            ptr_q <= '0;
        end else begin
            tlb_q <= tlb_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/immu_sv39_tlb.sv
// Instruction MMU: fetch VA -> iTLB lookup -> Sv39 hardware walk on miss -> PA to icache.
//  clk, rst_n                     clock, async active-low reset
//  current_priv_status, satp_*    privilege and translation context, sampled at fetch accept
//  sflush_*, flush_flag           sfence.vma request/ack; flush_flag pulses with the ack
//  immu_ar*/immu_r*               PTE read port into the dcache
//  mmu_fifo_valid/ready, vaddr    fetch address input
//  paddr_valid/ready, paddr,      translation result; on fault paddr carries vaddr
//  paddr_error
module immu_sv39_tlb
    import immu_pkg::*;
#(
    parameter int TLB_ENTRIES = 8,
    parameter int ASID_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  current_priv_status,
    input  logic [3:0]  satp_mode,
    input  logic [15:0] satp_asid,
    input  logic [43:0] satp_ppn,
    output logic        flush_flag,
    input  logic        sflush_vma_valid,
    output logic        sflush_vma_ready,
    input  logic [63:0] sflush_vaddr,
    input  logic [15:0] sflush_asid,
    input  logic        sflush_rs1_zero,
    input  logic        sflush_rs2_zero,
    input  logic        immu_arready,
    output logic        immu_arvalid,
    output logic        immu_aruser,
    output logic [63:0] immu_araddr,
    output logic        immu_rready,
    input  logic        immu_rvalid,
    input  logic [1:0]  immu_rresp,
    input  logic [63:0] immu_rdata,
    input  logic        mmu_fifo_valid,
    output logic        mmu_fifo_ready,
    input  logic [63:0] vaddr,
    output logic        paddr_valid,
    input  logic        paddr_ready,
    output logic [63:0] paddr,
    output logic        paddr_error
);

    immu_state_e state_q, state_d;
    logic [63:0] vaddr_q, vaddr_d;
    logic [1:0]  priv_q, priv_d;
    logic [3:0]  mode_q, mode_d;
    logic [15:0] asid_q, asid_d;
    logic [43:0] root_q, root_d;
    logic [1:0]  level_q, level_d;
    logic [43:0] base_q, base_d;
    logic [63:0] paddr_q, paddr_d;
    logic        err_q, err_d;

    logic        translate, canonical, priv_u;
    logic [8:0]  walk_vpn;
    logic        tlb_hit, hit_x, hit_u, hit_fault;
    logic [1:0]  hit_level;
    logic [43:0] hit_ppn;
    logic [43:0] pte_ppn;
    logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_g, pte_a;
    logic        pte_leaf, pte_misal, pte_u_bad, pte_fault, fill;
    logic        unused_bits;

    assign translate = (mode_q == SATP_MODE_SV39) && (priv_q != 2'd3);
    assign canonical = (vaddr_q[63:39] == {25{vaddr_q[38]}});
    assign priv_u    = (priv_q == 2'd0);

    always_comb begin
        case (level_q)
            2'd2:    walk_vpn = vaddr_q[38:30];
            2'd1:    walk_vpn = vaddr_q[29:21];
            default: walk_vpn = vaddr_q[20:12];
        endcase
    end

    assign pte_ppn = immu_rdata[53:10];
    assign pte_v   = immu_rdata[PTE_V];
    assign pte_r   = immu_rdata[PTE_R];
    assign pte_w   = immu_rdata[PTE_W];
    assign pte_x   = immu_rdata[PTE_X];
    assign pte_u   = immu_rdata[PTE_U];
    assign pte_g   = immu_rdata[PTE_G];
    assign pte_a   = immu_rdata[PTE_A];

    assign pte_leaf  = pte_r | pte_x;
    assign pte_misal = (level_q == 2'd2) ? (|pte_ppn[17:0]) :
                       (level_q == 2'd1) ? (|pte_ppn[8:0])  : 1'b0;
    // S-mode may not execute from user pages (no SUM for instruction fetch).
    assign pte_u_bad = priv_u ? ~pte_u : pte_u;
    // A=0 faults instead of being set: no hardware A/D update.
    assign pte_fault = (immu_rresp != 2'b00) | ~pte_v | (~pte_r & pte_w)
                     | (~pte_leaf & (level_q == 2'd0))
                     | (pte_leaf & (pte_misal | ~pte_x | ~pte_a | pte_u_bad));
    assign fill      = (state_q == ST_WALK_R) && immu_rvalid && pte_leaf && !pte_fault;
    assign hit_fault = ~hit_x | (priv_u ? ~hit_u : hit_u);

    assign unused_bits = ^{immu_rdata[63:54], immu_rdata[PTE_D], sflush_vaddr[63:39],
                           sflush_vaddr[11:0]};

    immu_tlb #(
        .TLB_ENTRIES(TLB_ENTRIES),
        .ASID_W     (ASID_W)
    ) u_tlb (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .lookup_vpn_i    (vaddr_q[38:12]),
        .lookup_asid_i   (asid_q),
        .hit_o           (tlb_hit),
        .hit_level_o     (hit_level),
        .hit_ppn_o       (hit_ppn),
        .hit_x_o         (hit_x),
        .hit_u_o         (hit_u),
        .fill_i          (fill),
        .fill_vpn_i      (vaddr_q[38:12]),
        .fill_asid_i     (asid_q),
        .fill_g_i        (pte_g),
        .fill_level_i    (level_q),
        .fill_ppn_i      (pte_ppn),
        .fill_x_i        (pte_x),
        .fill_u_i        (pte_u),
        .flush_i         (state_q == ST_FLUSH),
        .flush_vpn_i     (sflush_vaddr[38:12]),
        .flush_asid_i    (sflush_asid),
        .flush_all_va_i  (sflush_rs1_zero),
        .flush_all_asid_i(sflush_rs2_zero)
    );

    always_comb begin
        state_d = state_q;
        vaddr_d = vaddr_q;
        priv_d  = priv_q;
        mode_d  = mode_q;
        asid_d  = asid_q;
        root_d  = root_q;
        level_d = level_q;
        base_d  = base_q;
        paddr_d = paddr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sflush_vma_valid) begin
                    state_d = ST_FLUSH;
                end else if (mmu_fifo_valid) begin
                    vaddr_d = vaddr;
                    priv_d  = current_priv_status;
                    mode_d  = satp_mode;
                    asid_d  = satp_asid;
                    root_d  = satp_ppn;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_RESP;
                paddr_d = vaddr_q;
                err_d   = 1'b0;
                if (translate) begin
                    if (!canonical) begin
                        err_d = 1'b1;
                    end else if (tlb_hit) begin
                        if (hit_fault) err_d = 1'b1;
                        else           paddr_d = leaf_paddr(hit_ppn, vaddr_q, hit_level);
                    end else begin
                        state_d = ST_WALK_AR;
                        level_d = 2'd2;
                        base_d  = root_q;
                    end
                end
            end
            ST_WALK_AR: begin
                if (immu_arready) state_d = ST_WALK_R;
            end
            ST_WALK_R: begin
                if (immu_rvalid) begin
                    if (pte_fault) begin
                        err_d   = 1'b1;
                        paddr_d = vaddr_q;
                        state_d = ST_RESP;
                    end else if (pte_leaf) begin
                        err_d   = 1'b0;
                        paddr_d = leaf_paddr(pte_ppn, vaddr_q, level_q);
                        state_d = ST_RESP;
                    end else begin
                        level_d = level_q - 2'd1;
                        base_d  = pte_ppn;
                        state_d = ST_WALK_AR;
                    end
                end
            end
            ST_RESP: begin
                if (paddr_ready) state_d = ST_IDLE;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vaddr_q <= '0;
            priv_q  <= '0;
            mode_q  <= '0;
            asid_q  <= '0;
            root_q  <= '0;
            level_q <= '0;
            base_q  <= '0;
            paddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            priv_q  <= priv_d;
            mode_q  <= mode_d;
            asid_q  <= asid_d;
            root_q  <= root_d;
            level_q <= level_d;
            base_q  <= base_d;
            paddr_q <= paddr_d;
            err_q   <= err_d;
        end
    end

    assign immu_aruser      = 1'b1;
    assign immu_arvalid     = (state_q == ST_WALK_AR);
    assign immu_araddr      = (state_q == ST_WALK_AR) ? {8'b0, base_q, walk_vpn, 3'b000} : '0;
    assign immu_rready      = (state_q == ST_WALK_R);
    assign mmu_fifo_ready   = (state_q == ST_IDLE) && !sflush_vma_valid;
    assign paddr_valid      = (state_q == ST_RESP);
    assign paddr            = paddr_q;
    assign paddr_error      = err_q;
    assign sflush_vma_ready = (state_q == ST_FLUSH);
    assign flush_flag       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_immu_sv39_tlb.sv
module tb_immu_sv39_tlb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  current_priv_status = 2'd1;
    logic [3:0]  satp_mode = 4'd0;
    logic [15:0] satp_asid = 16'd0;
    logic [43:0] satp_ppn = 44'd0;
    logic        flush_flag;
    logic        sflush_vma_valid = 1'b0;
    logic        sflush_vma_ready;
    logic [63:0] sflush_vaddr = 64'd0;
    logic [15:0] sflush_asid = 16'd0;
    logic        sflush_rs1_zero = 1'b0;
    logic        sflush_rs2_zero = 1'b0;
    logic        immu_arready = 1'b1;
    logic        immu_arvalid;
    logic        immu_aruser;
    logic [63:0] immu_araddr;
    logic        immu_rready;
    logic        immu_rvalid = 1'b0;
    logic [1:0]  immu_rresp = 2'd0;
    logic [63:0] immu_rdata = 64'd0;
    logic        mmu_fifo_valid = 1'b0;
    logic        mmu_fifo_ready;
    logic [63:0] vaddr = 64'd0;
    logic        paddr_valid;
    logic        paddr_ready = 1'b0;
    logic [63:0] paddr;
    logic        paddr_error;

    always #5 clk = ~clk;

    immu_sv39_tlb #(.TLB_ENTRIES(8), .ASID_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .current_priv_status(current_priv_status),
        .satp_mode(satp_mode), .satp_asid(satp_asid), .satp_ppn(satp_ppn),
        .flush_flag(flush_flag), .sflush_vma_valid(sflush_vma_valid),
        .sflush_vma_ready(sflush_vma_ready), .sflush_vaddr(sflush_vaddr),
        .sflush_asid(sflush_asid), .sflush_rs1_zero(sflush_rs1_zero),
        .sflush_rs2_zero(sflush_rs2_zero), .immu_arready(immu_arready),
        .immu_arvalid(immu_arvalid), .immu_aruser(immu_aruser), .immu_araddr(immu_araddr),
        .immu_rready(immu_rready), .immu_rvalid(immu_rvalid), .immu_rresp(immu_rresp),
        .immu_rdata(immu_rdata), .mmu_fifo_valid(mmu_fifo_valid),
        .mmu_fifo_ready(mmu_fifo_ready), .vaddr(vaddr), .paddr_valid(paddr_valid),
        .paddr_ready(paddr_ready), .paddr(paddr), .paddr_error(paddr_error)
    );

    int          vecs = 0;
    int          errs = 0;
    int          ar_cnt = 0;
    logic        rhold = 1'b0;
    logic [63:0] err_addr = '1;
    logic [63:0] mem [logic [63:0]];
    logic        pend = 1'b0;
    logic [63:0] pend_addr = 64'd0;

    // dcache model: arready always 1, read data one cycle after the AR handshake.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            immu_rvalid = 1'b0;
            pend        = 1'b0;
        end else begin
            if (immu_rvalid) immu_rvalid = 1'b0;
            if (pend && !rhold) begin
                immu_rvalid = 1'b1;
                immu_rdata  = mem.exists(pend_addr) ? mem[pend_addr] : 64'd0;
                immu_rresp  = (pend_addr == err_addr) ? 2'd2 : 2'd0;
                pend        = 1'b0;
            end
            if (immu_arvalid) begin
                pend      = 1'b1;
                pend_addr = immu_araddr;
                ar_cnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] va_k(input int k);
        return 64'h4000_0000 + 64'(k) * 64'h1000;
    endfunction

    function automatic logic [63:0] pa_k(input int k);
        return (64'h9_0000 + 64'(k)) << 12;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, ".arvalid"}, 64'(immu_arvalid), 64'd0);
        chk({tag, ".araddr"}, immu_araddr, 64'd0);
        chk({tag, ".rready"}, 64'(immu_rready), 64'd0);
        chk({tag, ".pvalid"}, 64'(paddr_valid), 64'd0);
        chk({tag, ".paddr"}, paddr, 64'd0);
        chk({tag, ".perr"}, 64'(paddr_error), 64'd0);
        chk({tag, ".flush"}, 64'(flush_flag), 64'd0);
        chk({tag, ".sfready"}, 64'(sflush_vma_ready), 64'd0);
        chk({tag, ".aruser"}, 64'(immu_aruser), 64'd1);
    endtask

    // Latency counts edges from the accept edge to the first cycle with paddr_valid.
    task automatic fetch(input string tag, input logic [63:0] va, input logic [1:0] pv,
                         input logic [63:0] epa, input logic eerr, input int ears, input int elat);
        int a0;
        int cyc;
        a0 = ar_cnt;
        chk({tag, ".rdy"}, 64'(mmu_fifo_ready), 64'd1);
        vaddr = va;
        current_priv_status = pv;
        mmu_fifo_valid = 1'b1;
        @(posedge clk); #1;
        mmu_fifo_valid = 1'b0;
        cyc = 1;
        while (!paddr_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".vld"}, 64'(paddr_valid), 64'd1);
        chk({tag, ".lat"}, 64'(cyc), 64'(elat));
        chk({tag, ".pa"}, paddr, epa);
        chk({tag, ".err"}, 64'(paddr_error), 64'(eerr));
        chk({tag, ".ar"}, 64'(ar_cnt - a0), 64'(ears));
        paddr_ready = 1'b1;
        @(posedge clk); #1;
        paddr_ready = 1'b0;
    endtask

    task automatic sfence(input string tag, input logic [15:0] asid, input logic rs1z,
                          input logic rs2z);
        int rc;
        int fc;
        int n;
        rc = 0; fc = 0; n = 0;
        sflush_asid = asid;
        sflush_rs1_zero = rs1z;
        sflush_rs2_zero = rs2z;
        sflush_vma_valid = 1'b1;
        while (!sflush_vma_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (sflush_vma_ready) rc++;
            if (flush_flag) fc++;
        end
        @(posedge clk); #1;
        sflush_vma_valid = 1'b0;
        repeat (4) begin
            if (sflush_vma_ready) rc++;
            if (flush_flag) fc++;
            @(posedge clk); #1;
        end
        chk({tag, ".ready_pulses"}, 64'(rc), 64'd1);
        chk({tag, ".flush_pulses"}, 64'(fc), 64'd1);
    endtask

    initial begin
        int n;
        // Root 0x100: VPN2=1 -> 0x101; 0x101: VPN1=0 -> 0x102, VPN1=1 -> misaligned 2M leaf.
        mem[64'h10_0008] = (64'h101 << 10) | 64'h01;
        mem[64'h10_1000] = (64'h102 << 10) | 64'h01;
        mem[64'h10_1008] = (64'h8_0001 << 10) | 64'h49;
        mem[64'h10_2010] = (64'h8_7654 << 10) | 64'h49;
        for (int k = 3; k <= 10; k++)
            mem[64'h10_2000 + 64'(k) * 8] = ((64'h9_0000 + 64'(k)) << 10) |
                                            ((k >= 9) ? 64'h69 : 64'h49);

        #2 rst_n = 1'b0;
        #1 chk_quiet("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        satp_mode = 4'd0;
        fetch("bare", 64'h8000_1000, 2'd1, 64'h8000_1000, 1'b0, 0, 2);

        satp_mode = 4'd8;
        satp_asid = 16'd5;
        satp_ppn  = 44'h100;
        fetch("walk3", 64'h4000_2000, 2'd1, 64'h8765_4000, 1'b0, 3, 8);
        fetch("hit", 64'h4000_2000, 2'd1, 64'h8765_4000, 1'b0, 0, 2);
        fetch("misal", 64'h4020_0000, 2'd1, 64'h4020_0000, 1'b1, 2, 6);
        fetch("misal_nofill", 64'h4020_0000, 2'd1, 64'h4020_0000, 1'b1, 2, 6);
        fetch("ufault", 64'h4000_2000, 2'd0, 64'h4000_2000, 1'b1, 0, 2);
        err_addr = 64'h10_0008;
        fetch("rresp", 64'h4060_0000, 2'd1, 64'h4060_0000, 1'b1, 1, 4);
        err_addr = '1;
        fetch("noncanon", 64'h0000_0080_0000_0000, 2'd1, 64'h0000_0080_0000_0000, 1'b1, 0, 2);

        for (int k = 3; k <= 10; k++)
            fetch($sformatf("fill%0d", k), va_k(k), 2'd1, pa_k(k), 1'b0, 3, 8);
        fetch("evicted", 64'h4000_2000, 2'd1, 64'h8765_4000, 1'b0, 3, 8);
        fetch("hit4", va_k(4), 2'd1, pa_k(4), 1'b0, 0, 2);

        sfence("sf_asid5", 16'd5, 1'b1, 1'b0);
        fetch("flushed4", va_k(4), 2'd1, pa_k(4), 1'b0, 3, 8);
        fetch("global9", va_k(9), 2'd1, pa_k(9), 1'b0, 0, 2);
        fetch("global10", va_k(10), 2'd1, pa_k(10), 1'b0, 0, 2);

        vaddr = va_k(9);
        mmu_fifo_valid = 1'b1;
        @(posedge clk); #1;
        mmu_fifo_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("hold.vld", 64'(paddr_valid), 64'd1);
            chk("hold.pa", paddr, pa_k(9));
            @(posedge clk); #1;
        end
        paddr_ready = 1'b1;
        @(posedge clk); #1;
        paddr_ready = 1'b0;
        chk("hold.released", 64'(paddr_valid), 64'd0);

        rhold = 1'b1;
        vaddr = va_k(3);
        mmu_fifo_valid = 1'b1;
        @(posedge clk); #1;
        mmu_fifo_valid = 1'b0;
        n = 0;
        while (!immu_rready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midwalk.rready", 64'(immu_rready), 64'd1);
        rst_n = 1'b0;
        #1 chk_quiet("midwalk_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rhold = 1'b0;
        @(posedge clk); #1;
        fetch("tlb_empty9", va_k(9), 2'd1, pa_k(9), 1'b0, 3, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
